// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Initiator side of the NBitALU operand/select interface. Accepts one decoded
// instruction request (valid/ready) and translates ALUOp/funct3/funct7[5] into
// the 4-bit ALU select. It drives registered operands to the ALU, captures the
// result and zero flag one cycle later, and returns them on a valid/ready
// response channel.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_valid/ready   request handshake
//   req_aluop         00 ADD, 01 SUB, 10 R-type decode, 11 reserved
//   req_funct3        instruction funct3
//   req_funct7_5      instruction bit 30
//   req_a, req_b      operands
//   alu_a, alu_b      registered operands to the ALU
//   alu_sel           registered ALU select (AND 0000, OR 0001, ADD 0010, SUB 0110)
//   alu_result        ALU result, combinational from alu_a/alu_b/alu_sel
//   alu_zero          ALU zero flag
//   rsp_valid/ready   response handshake
//   rsp_result        captured result
//   rsp_zero          captured zero flag
//   rsp_illegal       request had an unsupported encoding
//   busy              controller is not idle
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_aluop,
   input  logic [2:0]   req_funct3,
   input  logic         req_funct7_5,
   input  logic [N-1:0] req_a,
   input  logic [N-1:0] req_b,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_sel,
   input  logic [N-1:0] alu_result,
   input  logic         alu_zero,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_result,
   output logic         rsp_zero,
   output logic         rsp_illegal,
   output logic         busy
);

   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0010;
   localparam logic [3:0] SEL_SUB = 4'b0110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] dec_sel;
   logic       dec_illegal;
   logic       accept;
   logic       load_ops;
   logic       cap_alu;
   logic       cap_illegal;

   // Instruction decode, purely from the request fields.
   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      dec_sel     = SEL_ADD;
      dec_illegal = 1'b0;
      case (req_aluop)
         2'b00: dec_sel = SEL_ADD;
         2'b01: dec_sel = SEL_SUB;
         2'b10: begin
            case (req_funct3)
               3'b000:  dec_sel = req_funct7_5 ? SEL_SUB : SEL_ADD;
               3'b111:  dec_sel = SEL_AND;
               3'b110:  dec_sel = SEL_OR;
               default: dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // A new request may enter while idle, or while a response leaves in the
   // same cycle. Depends only on state, rst and rsp_ready.
   assign req_ready = !rst && ((state == IDLE) || ((state == RESP) && rsp_ready));
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   // Next-state and datapath load enables.
   always_comb begin
      state_nxt   = state;
      load_ops    = 1'b0;
      cap_alu     = 1'b0;
      cap_illegal = 1'b0;
      case (state)
         IDLE, RESP: begin
            if (accept) begin
               if (dec_illegal) begin
                  cap_illegal = 1'b1;
                  state_nxt   = RESP;
               end else begin
                  load_ops  = 1'b1;
                  state_nxt = ISSUE;
               end
            end else if ((state == RESP) && rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         ISSUE: begin
            // ALU output has settled on the registered operands; capture it.
            cap_alu   = 1'b1;
            state_nxt = RESP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and datapath registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_sel     <= SEL_ADD;
         rsp_result  <= '0;
         rsp_zero    <= 1'b0;
         rsp_illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_ops) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_sel <= dec_sel;
         end
         if (cap_alu) begin
            rsp_result  <= alu_result;
            rsp_zero    <= alu_zero;
            rsp_illegal <= 1'b0;
         end
         if (cap_illegal) begin
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed testbench for alu_issue_ctrl. A small behavioural ALU is attached
// to the alu_* port; inputs change 1 ns after a rising edge and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_aluop;
   logic [2:0]   req_funct3;
   logic         req_funct7_5;
   logic [N-1:0] req_a;
   logic [N-1:0] req_b;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [3:0]   alu_sel;
   logic [N-1:0] alu_result;
   logic         alu_zero;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [N-1:0] rsp_result;
   logic         rsp_zero;
   logic         rsp_illegal;
   logic         busy;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_aluop    (req_aluop),
      .req_funct3   (req_funct3),
      .req_funct7_5 (req_funct7_5),
      .req_a        (req_a),
      .req_b        (req_b),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_sel      (alu_sel),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .rsp_illegal  (rsp_illegal),
      .busy         (busy)
   );

   // Attached ALU.
   always_comb begin
      alu_result = '0;
      case (alu_sel)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         default: alu_result = '0;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                            input logic [N-1:0] a, input logic [N-1:0] b);
      req_valid    = 1'b1;
      req_aluop    = op;
      req_funct3   = f3;
      req_funct7_5 = f7;
      req_a        = a;
      req_b        = b;
   endtask

   // Legal request from IDLE with rsp_ready held high.
   task automatic run_legal(input string tag, input logic [1:0] op, input logic [2:0] f3,
                            input logic f7, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [3:0] esel, input logic [N-1:0] eres, input logic ezero);
      drive_req(op, f3, f7, a, b);
      @(negedge clk);
      check({tag, " idle req_ready"}, 64'(req_ready), 64'(1'b1));
      tick();                       // accept edge T
      req_valid = 1'b0;
      @(negedge clk);
      check({tag, " issue rsp_valid"}, 64'(rsp_valid), 64'(1'b0));
      check({tag, " issue req_ready"}, 64'(req_ready), 64'(1'b0));
      check({tag, " issue busy"}, 64'(busy), 64'(1'b1));
      check({tag, " alu_sel"}, 64'(alu_sel), 64'(esel));
      check({tag, " alu_a"}, 64'(alu_a), 64'(a));
      check({tag, " alu_b"}, 64'(alu_b), 64'(b));
      tick();                       // capture edge T+1
      @(negedge clk);
      check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1'b1));
      check({tag, " rsp_result"}, 64'(rsp_result), 64'(eres));
      check({tag, " rsp_zero"}, 64'(rsp_zero), 64'(ezero));
      check({tag, " rsp_illegal"}, 64'(rsp_illegal), 64'(1'b0));
      tick();                       // response consumed
      @(negedge clk);
      check({tag, " back idle"}, 64'(busy), 64'(1'b0));
      tick();
   endtask

   // Illegal request from IDLE; ALU-facing registers must keep prior values.
   task automatic run_illegal(input string tag, input logic [1:0] op, input logic [2:0] f3,
                              input logic f7, input logic [N-1:0] pa, input logic [N-1:0] pb,
                              input logic [3:0] psel);
      drive_req(op, f3, f7, 32'h1234_5678, 32'h9ABC_DEF0);
      tick();                       // accept edge T
      req_valid = 1'b0;
      @(negedge clk);
      check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1'b1));
      check({tag, " rsp_illegal"}, 64'(rsp_illegal), 64'(1'b1));
      check({tag, " rsp_result"}, 64'(rsp_result), 64'(0));
      check({tag, " rsp_zero"}, 64'(rsp_zero), 64'(1'b0));
      check({tag, " alu_a kept"}, 64'(alu_a), 64'(pa));
      check({tag, " alu_b kept"}, 64'(alu_b), 64'(pb));
      check({tag, " alu_sel kept"}, 64'(alu_sel), 64'(psel));
      tick();                       // response consumed
      @(negedge clk);
      check({tag, " back idle"}, 64'(busy), 64'(1'b0));
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, observed time %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_aluop    = 2'b00;
      req_funct3   = 3'b000;
      req_funct7_5 = 1'b0;
      req_a        = '0;
      req_b        = '0;
      rsp_ready    = 1'b1;

      // Reset
      tick();
      req_valid = 1'b1;
      @(negedge clk);
      check("reset req_ready forced low", 64'(req_ready), 64'(1'b0));
      tick();
      req_valid = 1'b0;
      rst       = 1'b0;
      @(negedge clk);
      check("reset alu_a", 64'(alu_a), 64'(0));
      check("reset alu_b", 64'(alu_b), 64'(0));
      check("reset alu_sel", 64'(alu_sel), 64'(4'b0010));
      check("reset rsp_valid", 64'(rsp_valid), 64'(1'b0));
      check("reset rsp_result", 64'(rsp_result), 64'(0));
      check("reset rsp_zero", 64'(rsp_zero), 64'(1'b0));
      check("reset rsp_illegal", 64'(rsp_illegal), 64'(1'b0));
      check("reset busy", 64'(busy), 64'(1'b0));
      tick();

      // Legal decodes
      run_legal("rtype add", 2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0);
      run_legal("aluop sub", 2'b01, 3'b000, 1'b0, 32'd9, 32'd9, 4'b0110, 32'd0, 1'b1);
      run_legal("rtype sub", 2'b10, 3'b000, 1'b1, 32'd3, 32'd5, 4'b0110, 32'hFFFF_FFFE, 1'b0);
      run_legal("ld/st add f3 ignored", 2'b00, 3'b111, 1'b1, 32'h10, 32'h20, 4'b0010, 32'h30, 1'b0);
      run_legal("branch sub f7 ignored", 2'b01, 3'b110, 1'b1, 32'h10, 32'h4, 4'b0110, 32'hC, 1'b0);
      run_legal("rtype and", 2'b10, 3'b111, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0,
                4'b0000, 32'h0000_00F0, 1'b0);
      run_legal("rtype or", 2'b10, 3'b110, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0,
                4'b0001, 32'h0000_FFF0, 1'b0);

      // Illegal encodings
      run_illegal("illegal f3=001", 2'b10, 3'b001, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0001);
      run_illegal("illegal aluop=11", 2'b11, 3'b000, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0001);
      run_illegal("illegal f3=100", 2'b10, 3'b100, 1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0001);

      // Back-pressure in RESP, then back-to-back accept
      rsp_ready = 1'b0;
      drive_req(2'b00, 3'b000, 1'b0, 32'd100, 32'd23);
      tick();                       // accept
      req_valid = 1'b0;
      tick();                       // capture -> RESP
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall rsp_valid", 64'(rsp_valid), 64'(1'b1));
         check("stall rsp_result", 64'(rsp_result), 64'(123));
         check("stall rsp_illegal", 64'(rsp_illegal), 64'(1'b0));
         check("stall req_ready", 64'(req_ready), 64'(1'b0));
         tick();
      end
      rsp_ready = 1'b1;
      drive_req(2'b01, 3'b000, 1'b0, 32'd50, 32'd8);
      @(negedge clk);
      check("b2b req_ready", 64'(req_ready), 64'(1'b1));
      check("b2b old rsp_result", 64'(rsp_result), 64'(123));
      tick();                       // old response leaves, new request accepted
      req_valid = 1'b0;
      @(negedge clk);
      check("b2b issue rsp_valid", 64'(rsp_valid), 64'(1'b0));
      check("b2b issue busy", 64'(busy), 64'(1'b1));
      check("b2b alu_sel", 64'(alu_sel), 64'(4'b0110));
      check("b2b alu_a", 64'(alu_a), 64'(50));
      tick();                       // capture
      // Illegal request accepted while the SUB response leaves
      drive_req(2'b11, 3'b111, 1'b0, 32'd1, 32'd1);
      @(negedge clk);
      check("b2b rsp_valid", 64'(rsp_valid), 64'(1'b1));
      check("b2b rsp_result", 64'(rsp_result), 64'(42));
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      check("b2b illegal rsp_valid", 64'(rsp_valid), 64'(1'b1));
      check("b2b illegal flag", 64'(rsp_illegal), 64'(1'b1));
      check("b2b illegal result", 64'(rsp_result), 64'(0));
      check("b2b illegal alu_sel kept", 64'(alu_sel), 64'(4'b0110));
      tick();
      @(negedge clk);
      check("b2b back idle", 64'(busy), 64'(1'b0));
      tick();

      // Reset while in ISSUE
      drive_req(2'b00, 3'b000, 1'b0, 32'd1, 32'd2);
      tick();                       // accept -> ISSUE
      req_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      check("rst issue busy before", 64'(busy), 64'(1'b1));
      check("rst issue req_ready", 64'(req_ready), 64'(1'b0));
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst issue busy", 64'(busy), 64'(1'b0));
      check("rst issue rsp_valid", 64'(rsp_valid), 64'(1'b0));
      check("rst issue alu_sel", 64'(alu_sel), 64'(4'b0010));
      check("rst issue alu_a", 64'(alu_a), 64'(0));
      check("rst issue alu_b", 64'(alu_b), 64'(0));
      tick();
      @(negedge clk);
      check("rst issue stays idle", 64'(rsp_valid), 64'(1'b0));
      tick();

      // Reset while in RESP under back-pressure
      rsp_ready = 1'b0;
      drive_req(2'b10, 3'b110, 1'b0, 32'h1, 32'h2);
      tick();
      req_valid = 1'b0;
      tick();
      @(negedge clk);
      check("rst resp rsp_valid before", 64'(rsp_valid), 64'(1'b1));
      check("rst resp rsp_result before", 64'(rsp_result), 64'(3));
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst resp rsp_valid", 64'(rsp_valid), 64'(1'b0));
      check("rst resp rsp_result", 64'(rsp_result), 64'(0));
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
